// File: rtl/grf_wport_arb.sv
// GRF write-port arbiter: the W stage has fixed priority, and MDU and BUS
// results share the slots it leaves free in round-robin order. The block also
// keeps a pending-write scoreboard and requests a W bubble when a secondary
// writer is starved.
module grf_wport_arb #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [4:0]  bus_a3,
  input  logic [31:0] bus_wd,
  input  logic        iss_en,
  input  logic [4:0]  iss_a3,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [1:0]  grf_src,
  output logic        stall_req,
  output logic [31:0] busy
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NREG = 32;

  logic             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             stall_req_q, stall_req_d;
  logic [NREG-1:0]  busy_q, busy_d;

  logic w_act;
  logic grant_mdu;
  logic grant_bus;

  // Same-cycle grant: W first, then the round-robin choice between MDU and BUS.
  // Nothing is granted while reset is held.
  always_comb begin
    grant_mdu = 1'b0;
    grant_bus = 1'b0;
    grf_we    = 1'b0;
    grf_a3    = '0;
    grf_wd    = '0;
    grf_src   = 2'd0;
    w_act     = wb_en && (wb_a3 != AW'(0));
    if (reset) begin
      if (w_act) begin
        grf_we  = 1'b1;
        grf_a3  = wb_a3;
        grf_wd  = wb_wd;
        grf_src = 2'd1;
      end else if (mdu_valid && (!bus_valid || !rr_ptr_q)) begin
        grant_mdu = 1'b1;
        grf_src   = 2'd2;
        grf_we    = (mdu_a3 != AW'(0));
        grf_a3    = mdu_a3;
        grf_wd    = (mdu_a3 != AW'(0)) ? mdu_wd : DW'(0);
      end else if (bus_valid) begin
        grant_bus = 1'b1;
        grf_src   = 2'd3;
        grf_we    = (bus_a3 != AW'(0));
        grf_a3    = bus_a3;
        grf_wd    = (bus_a3 != AW'(0)) ? bus_wd : DW'(0);
      end
    end
    mdu_ready = grant_mdu;
    bus_ready = grant_bus;
  end

  // Next state: round-robin pointer, starvation counter, stall flag, scoreboard.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    busy_d     = busy_q;
    if (grant_mdu) begin
      rr_ptr_d = 1'b1;
    end else if (grant_bus) begin
      rr_ptr_d = 1'b0;
    end
    if (grant_mdu || grant_bus || !(mdu_valid || bus_valid)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_W'(STARVE_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    stall_req_d = (wait_cnt_d == CNT_W'(STARVE_LIMIT));
    // A clear and a set of the same register in one cycle leave it set.
    if (grant_mdu) begin
      busy_d[mdu_a3] = 1'b0;
    end
    if (grant_bus) begin
      busy_d[bus_a3] = 1'b0;
    end
    if (iss_en) begin
      busy_d[iss_a3] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= 1'b0;
      wait_cnt_q  <= '0;
      stall_req_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_req_q <= stall_req_d;
      busy_q      <= busy_d;
    end
  end

  assign stall_req = stall_req_q;
  assign busy      = busy_q;

endmodule

// File: doc/grf_wport_arb.md
Name: grf_wport_arb

Overview:
- Owns the single write port of the general register file and shares it between three writers:
  - the pipeline W stage (fixed top priority, never back-pressured);
  - the multiply/divide unit result return (MDU);
  - the bus/load return path (BUS).
- MDU and BUS use valid/ready handshakes and are served round-robin in cycles the W stage leaves free.
- Keeps a per-register pending-write scoreboard for hazard detection.
- Raises a stall request to open a W-stage bubble when a secondary writer is starved.

Parameters:
- STARVE_LIMIT, 4, consecutive waiting cycles after which stall_req asserts (1..7).
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- wb_en  input  1  W-stage write enable
- wb_a3  input  5  W-stage destination register
- wb_wd  input  32  W-stage write data
- mdu_valid  input  1  MDU has a result to write
- mdu_ready  output  1  MDU result accepted this cycle
- mdu_a3  input  5  MDU destination
- mdu_wd  input  32  MDU data
- bus_valid  input  1  BUS has load data to write
- bus_ready  output  1  BUS data accepted this cycle
- bus_a3  input  5  BUS destination
- bus_wd  input  32  BUS data
- iss_en  input  1  a long-latency op targeting iss_a3 issued this cycle
- iss_a3  input  5  destination of the issued op
- grf_we  output  1  to GRF RegWrite
- grf_a3  output  5  to GRF A3
- grf_wd  output  32  to GRF WD
- grf_src  output  2  winner: 0 none, 1 W, 2 MDU, 3 BUS
- stall_req  output  1  request to freeze the pipeline for one slot
- busy  output  32  scoreboard; bit r set means a write to $r is outstanding

Behaviour:
- Grant logic is combinational from the current inputs and registered state. The GRF write happens at the same rising edge, so grant-to-write latency is 0.
- The W stage is active when wb_en=1 and wb_a3!=0. An active W stage always wins (grf_src=1); mdu_ready=bus_ready=0.
- W stage with wb_en=1 and wb_a3=0 counts as idle, so the slot goes to a secondary writer.
- W idle, exactly one secondary valid: that writer is granted (ready=1, grf_src=2/3).
- W idle, both secondaries valid: rr_ptr selects the winner (0 means MDU preferred, 1 means BUS preferred). The loser sees ready=0 and must hold valid, a3 and wd stable.
- rr_ptr update:
  - after an MDU grant, rr_ptr<=1;
  - after a BUS grant, rr_ptr<=0;
  - otherwise unchanged.
- No grant: grf_we=0; grf_a3 and grf_wd driven to 0.
- A granted secondary with a3=0 is consumed (ready=1) with grf_we=0.
- Starvation counter wait_cnt:
  - increments, saturating at STARVE_LIMIT, in each cycle where any secondary is valid and none is granted;
  - clears to 0 on any secondary grant or when no secondary is valid.
- stall_req = (wait_cnt==STARVE_LIMIT); it is registered-state driven, with no combinational path from the valid inputs.
- The pipeline answers stall_req with a W bubble (wb_en=0) in the same cycle. The secondary is granted, and wait_cnt and stall_req fall the next cycle.
- Scoreboard:
  - iss_en with iss_a3!=0 sets busy[iss_a3] at the edge;
  - a secondary grant to register r clears busy[r] at the edge;
  - set and clear of the same register in the same cycle: set wins;
  - busy[0] is constant 0;
  - W-stage writes never touch busy.
- Reset (reset=0, asynchronous):
  - busy=0, rr_ptr=0, wait_cnt=0, stall_req=0;
  - mdu_ready=bus_ready=0, grf_we=0, grf_src=0, grf_a3=0, grf_wd=0 while reset is held.
- Reset mid-handshake drops pending requests. Requesters must re-present them after reset is released.

Test Plan:
- Reset low, then release; drive only wb_en=1, wb_a3=8, wb_wd=0x1234 -> grf_we=1, grf_a3=8, grf_wd=0x1234, grf_src=1; busy=0, stall_req=0.
- W idle; mdu_valid and bus_valid both held for 4 cycles with mdu_a3=3, bus_a3=4, each dropping valid after its grant -> grants in order MDU, BUS; rr_ptr toggles each grant; each write completes in one cycle.
- iss_en with iss_a3=5, then MDU returns a3=5 two cycles later with W idle -> busy[5] rises one edge after issue and clears at the grant edge. Same test with iss_a3=5 re-issued in the grant cycle -> busy[5] stays 1.
- wb_en=1 with nonzero wb_a3 every cycle while bus_valid=1 -> wait_cnt reaches 4 and stall_req=1. Drive wb_en=0 -> bus_ready=1 that cycle; stall_req=0 on the next edge.
- wb_en=1 with wb_a3=0 and mdu_valid=1 (a3=7, wd=0xDEAD) -> mdu granted, grf_a3=7. iss_en with iss_a3=0 -> busy[0] stays 0.
- Assert reset=0 asynchronously between edges while busy=0x00000030, wait_cnt=3 and mdu_valid=1 -> busy, stall_req and mdu_ready drop to 0 immediately, without waiting for a clock edge.
